// File: rtl/axil_led_bram_slave_if.sv
// AXI4-Lite slave-side channel bundle for axil_led_bram_slave.
// Member names carry the s_axi_ prefix so they read the same as the host-side port list.
interface axil_led_bram_slave_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_led_bram_slave.sv
// AXI4-Lite register file (LED, SCRATCH, ID, WRCNT) driving the 8-bit LED bus; AXIL_LED_BLINK_EN adds BLINK at 0x010.
// Latency: B on the edge both AW and W are held; R one cycle after the AR handshake.
// Backpressure: AW/W stall while a B is pending; AR stalls while an R is pending.
module axil_led_bram_slave #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] ID_VALUE = 32'hA0C0_0001,
    parameter logic [7:0]  LED_RST  = 8'h00
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axil_led_bram_slave_if.slave  s_axi,
    output logic [7:0]            led_8bits_tri_o
);
    localparam int WI_W = ADDR_W - 2;
    localparam logic [WI_W-1:0] WI_LED = WI_W'(0);
    localparam logic [WI_W-1:0] WI_SCR = WI_W'(1);
    localparam logic [WI_W-1:0] WI_ID  = WI_W'(2);
    localparam logic [WI_W-1:0] WI_CNT = WI_W'(3);
`ifdef AXIL_LED_BLINK_EN
    localparam logic [WI_W-1:0] WI_BLK = WI_W'(4);
`endif

    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic            rdy_en_q,   rdy_en_d;
    logic            aw_held_q,  aw_held_d;
    logic [WI_W-1:0] awidx_q,    awidx_d;
    logic            w_held_q,   w_held_d;
    logic [31:0]     wdata_q,    wdata_d;
    logic [3:0]      wstrb_q,    wstrb_d;
    logic            bvalid_q,   bvalid_d;
    logic [1:0]      bresp_q,    bresp_d;
    logic [7:0]      led_q,      led_d;
    logic [31:0]     scratch_q,  scratch_d;
    logic [31:0]     wrcnt_q,    wrcnt_d;
`ifdef AXIL_LED_BLINK_EN
    logic [31:0]     blink_q,    blink_d;
    logic [23:0]     bcnt_q,     bcnt_d;
    logic            phase_q,    phase_d;
`endif

    rstate_t         rstate_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic [1:0]      rresp_q;

    logic            aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [WI_W-1:0] wr_idx, rd_idx;
    logic [31:0]     wr_data, rd_dat;
    logic [3:0]      wr_strb;
    logic            rd_err;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

    // Readies stay low through reset and rise one cycle after release.
    assign s_axi.s_axi_awready = rdy_en_q && !aw_held_q && !bvalid_q;
    assign s_axi.s_axi_wready  = rdy_en_q && !w_held_q  && !bvalid_q;
    assign s_axi.s_axi_arready = rdy_en_q && (rstate_q == R_IDLE);
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

    assign aw_hs = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_hs  = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
    assign ar_hs = s_axi.s_axi_arvalid && s_axi.s_axi_arready;

    always_comb begin
        wr_idx  = aw_held_q ? awidx_q : s_axi.s_axi_awaddr[ADDR_W-1:2];
        wr_data = w_held_q  ? wdata_q : s_axi.s_axi_wdata;
        wr_strb = w_held_q  ? wstrb_q : s_axi.s_axi_wstrb;
        commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
        wr_ok   = (wr_idx == WI_LED) || (wr_idx == WI_SCR)
`ifdef AXIL_LED_BLINK_EN
                  || (wr_idx == WI_BLK)
`endif
                  ;

        rdy_en_d  = 1'b1;
        aw_held_d = aw_held_q;
        awidx_d   = awidx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        led_d     = led_q;
        scratch_d = scratch_q;
        wrcnt_d   = wrcnt_q;
`ifdef AXIL_LED_BLINK_EN
        blink_d   = blink_q;
`endif

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi.s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.s_axi_wdata;
            wstrb_d  = s_axi.s_axi_wstrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? 2'b00 : 2'b10;
            if (wr_ok) begin
                wrcnt_d = wrcnt_q + 32'd1;
            end
            if (wr_idx == WI_LED && wr_strb[0]) begin
                led_d = wr_data[7:0];
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_idx == WI_SCR && wr_strb[i]) begin
                    scratch_d[8*i +: 8] = wr_data[8*i +: 8];
                end
`ifdef AXIL_LED_BLINK_EN
                if (wr_idx == WI_BLK && wr_strb[i]) begin
                    blink_d[8*i +: 8] = wr_data[8*i +: 8];
                end
`endif
            end
        end else if (bvalid_q && s_axi.s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

`ifdef AXIL_LED_BLINK_EN
    // Period 0 parks the phase low so the LEDs show the raw register.
    always_comb begin
        bcnt_d  = 24'd0;
        phase_d = 1'b0;
        if (blink_q[31:8] != 24'd0) begin
            if (bcnt_q == blink_q[31:8]) begin
                bcnt_d  = 24'd0;
                phase_d = !phase_q;
            end else begin
                bcnt_d  = bcnt_q + 24'd1;
                phase_d = phase_q;
            end
        end
    end

    assign led_8bits_tri_o = led_q ^ (blink_q[7:0] & {8{phase_q}});
`else
    assign led_8bits_tri_o = led_q;
`endif

    // Read mux sees pre-commit register values, so a same-edge write is not visible.
    always_comb begin
        rd_idx = s_axi.s_axi_araddr[ADDR_W-1:2];
        rd_dat = 32'd0;
        rd_err = 1'b0;
        case (rd_idx)
            WI_LED:  rd_dat = {24'd0, led_q};
            WI_SCR:  rd_dat = scratch_q;
            WI_ID:   rd_dat = ID_VALUE;
            WI_CNT:  rd_dat = wrcnt_q;
`ifdef AXIL_LED_BLINK_EN
            WI_BLK:  rd_dat = blink_q;
`endif
            default: rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            awidx_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            led_q     <= LED_RST;
            scratch_q <= 32'd0;
            wrcnt_q   <= 32'd0;
`ifdef AXIL_LED_BLINK_EN
            blink_q   <= 32'd0;
            bcnt_q    <= 24'd0;
            phase_q   <= 1'b0;
`endif
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_held_q <= aw_held_d;
            awidx_q   <= awidx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            wrcnt_q   <= wrcnt_d;
`ifdef AXIL_LED_BLINK_EN
            blink_q   <= blink_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
`endif
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rresp_q  <= 2'b00;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate_q <= R_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_dat;
                        rresp_q  <= rd_err ? 2'b10 : 2'b00;
                    end
                end
                R_DATA: begin
                    if (s_axi.s_axi_rready) begin
                        rstate_q <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_led_bram_slave.sv
// Directed bench for axil_led_bram_slave: register map, handshake ordering, backpressure and mid-transaction reset.
module tb_axil_led_bram_slave;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    axil_led_bram_slave_if #(.ADDR_W(12)) bus ();

    axil_led_bram_slave #(
        .ADDR_W(12), .ID_VALUE(32'hA0C0_0001), .LED_RST(8'h00)
    ) dut (
        .ACLK(clk), .ARESET(rst), .s_axi(bus.slave), .led_8bits_tri_o(led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // aw_at/w_at: cycle on which each valid is first raised; bhold: cycles to stall bready.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_at, input int w_at, input int bhold,
                             output logic [1:0] resp, output logic ok, output logic hold_ok);
        int   c;
        logic aw_done, w_done, aw_hs, w_hs;
        logic [1:0] r0;
        ok = 1'b1; hold_ok = 1'b1; c = 0; aw_done = 1'b0; w_done = 1'b0;
        bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
        while (!(aw_done && w_done) && c < 40) begin
            bus.s_axi_awvalid = !aw_done && (c >= aw_at);
            bus.s_axi_wvalid  = !w_done  && (c >= w_at);
            aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
            w_hs  = bus.s_axi_wvalid  && bus.s_axi_wready;
            @(posedge clk); #1;
            aw_done = aw_done || aw_hs;
            w_done  = w_done  || w_hs;
            c++;
        end
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        if (!(aw_done && w_done) || !bus.s_axi_bvalid) ok = 1'b0;
        r0 = bus.s_axi_bresp;
        for (int i = 0; i < bhold; i++) begin
            @(posedge clk); #1;
            if (!bus.s_axi_bvalid || bus.s_axi_awready || bus.s_axi_wready || bus.s_axi_bresp !== r0)
                hold_ok = 1'b0;
        end
        resp = bus.s_axi_bresp;
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
        if (bus.s_axi_bvalid) ok = 1'b0;
        @(posedge clk); #1;
        if (bus.s_axi_bvalid) ok = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, input int rhold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic ok, output logic hold_ok);
        int   c;
        logic done, hs;
        ok = 1'b1; hold_ok = 1'b1; c = 0; done = 1'b0;
        bus.s_axi_araddr = addr;
        while (!done && c < 40) begin
            bus.s_axi_arvalid = 1'b1;
            hs = bus.s_axi_arready;
            @(posedge clk); #1;
            done = hs;
            c++;
        end
        bus.s_axi_arvalid = 1'b0;
        if (!done || !bus.s_axi_rvalid) ok = 1'b0;
        data = bus.s_axi_rdata; resp = bus.s_axi_rresp;
        for (int i = 0; i < rhold; i++) begin
            @(posedge clk); #1;
            if (!bus.s_axi_rvalid || bus.s_axi_arready || bus.s_axi_rdata !== data || bus.s_axi_rresp !== resp)
                hold_ok = 1'b0;
        end
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_rready = 1'b0;
        if (bus.s_axi_rvalid) ok = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok, hok, quiet;

        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0;
        bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

        repeat (20) @(posedge clk);
        #1;
        chk("rst_hold_flags", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready,
                                   bus.s_axi_bvalid, bus.s_axi_rvalid}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_flags", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready,
                              bus.s_axi_bvalid, bus.s_axi_rvalid}), 32'd0);
        chk("rel_led", 32'(led), 32'h00);
        chk("rel_rdata_resp", {bus.s_axi_rdata[27:0], bus.s_axi_bresp, bus.s_axi_rresp}, 32'd0);
        @(posedge clk); #1;
        chk("readies_up", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 32'b111);

        axi_read(12'h008, 0, d, r, ok, hok);
        chk("id_ok", 32'(ok), 32'd1);
        chk("id_data", d, 32'hA0C0_0001);
        chk("id_resp", 32'(r), 32'd0);

        axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, ok, hok);
        chk("led_wr_ok", 32'(ok), 32'd1);
        chk("led_wr_resp", 32'(r), 32'd0);
        chk("led_pins", 32'(led), 32'hFF);
        axi_read(12'h000, 0, d, r, ok, hok);
        chk("led_rd", d, 32'h0000_00FF);
        axi_read(12'h00C, 0, d, r, ok, hok);
        chk("wrcnt_1", d, 32'd1);

        axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, r, ok, hok);
        chk("scr_awfirst_ok", 32'(ok), 32'd1);
        chk("scr_awfirst_resp", 32'(r), 32'd0);
        axi_read(12'h004, 0, d, r, ok, hok);
        chk("scr_rd1", d, 32'hDEAD_BEEF);
        axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, r, ok, hok);
        chk("scr_wfirst_ok", 32'(ok), 32'd1);
        axi_read(12'h004, 0, d, r, ok, hok);
        chk("scr_rd2", d, 32'hDEAD_BEEF);
        axi_write(12'h004, 32'h0000_5500, 4'b0010, 0, 0, 0, r, ok, hok);
        axi_read(12'h004, 0, d, r, ok, hok);
        chk("scr_lane1", d, 32'hDEAD_55EF);
        axi_read(12'h007, 0, d, r, ok, hok);
        chk("scr_lsb_ignored", d, 32'hDEAD_55EF);

        axi_write(12'h008, 32'h1234_5678, 4'hF, 0, 0, 0, r, ok, hok);
        chk("id_wr_resp", 32'(r), 32'b10);
        axi_write(12'h100, 32'h1234_5678, 4'hF, 0, 0, 0, r, ok, hok);
        chk("unm_wr_resp", 32'(r), 32'b10);
        axi_write(12'h00C, 32'h0, 4'hF, 0, 0, 0, r, ok, hok);
        chk("cnt_wr_resp", 32'(r), 32'b10);
        axi_read(12'h100, 0, d, r, ok, hok);
        chk("unm_rd_resp", 32'(r), 32'b10);
        chk("unm_rd_data", d, 32'd0);
        axi_read(12'h010, 0, d, r, ok, hok);
        chk("blink_unmapped", 32'(r), 32'b10);
        axi_read(12'h008, 0, d, r, ok, hok);
        chk("id_unchanged", d, 32'hA0C0_0001);
        axi_read(12'h00C, 0, d, r, ok, hok);
        chk("wrcnt_4", d, 32'd4);

        axi_write(12'h004, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, r, ok, hok);
        chk("strb0_resp", 32'(r), 32'd0);
        axi_read(12'h004, 0, d, r, ok, hok);
        chk("strb0_noop", d, 32'hDEAD_55EF);
        axi_read(12'h00C, 0, d, r, ok, hok);
        chk("wrcnt_5", d, 32'd5);

        axi_write(12'h000, 32'h0000_005A, 4'b0001, 0, 0, 10, r, ok, hok);
        chk("bhold_ok", 32'(ok), 32'd1);
        chk("bhold_stable", 32'(hok), 32'd1);
        chk("led_5a", 32'(led), 32'h5A);
        axi_read(12'h00C, 10, d, r, ok, hok);
        chk("rhold_ok", 32'(ok), 32'd1);
        chk("rhold_stable", 32'(hok), 32'd1);
        chk("wrcnt_6", d, 32'd6);

        // Write and read to SCRATCH on the same edge, both left pending, then reset.
        bus.s_axi_awaddr = 12'h004; bus.s_axi_wdata = 32'h1234_5678; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_araddr = 12'h004;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        chk("both_pending", 32'({bus.s_axi_bvalid, bus.s_axi_rvalid}), 32'b11);
        chk("rd_pre_write", bus.s_axi_rdata, 32'hDEAD_55EF);
        rst = 1'b1;
        #1;
        chk("rst_drop", 32'({bus.s_axi_bvalid, bus.s_axi_rvalid}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.s_axi_bvalid || bus.s_axi_rvalid) quiet = 1'b0;
        end
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
        chk("no_stale_resp", 32'(quiet), 32'd1);
        chk("led_after_rst", 32'(led), 32'h00);
        axi_read(12'h004, 0, d, r, ok, hok);
        chk("scr_after_rst", d, 32'd0);
        axi_read(12'h00C, 0, d, r, ok, hok);
        chk("wrcnt_after_rst", d, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
